// File: rtl/pipeline_sequencer_if.sv
// Bundle of EX-stage inputs and sequencing outputs exchanged between the
// EX pipeline register / ALU / PC logic (master) and the sequencer (slave).
interface pipeline_sequencer_if #(
    parameter int CNT_W = 16
);
    // EX stage view presented to the sequencer
    logic             ex_instr_valid;
    logic [6:0]       ex_opcode;
    logic [2:0]       ex_funct3;
    logic [6:0]       ex_funct7;
    logic [31:0]      alu_result;
    logic [31:0]      pc_ex;
    logic [31:0]      imm_b_ext;
    logic [31:0]      imm_j_ext;

    // Sequencer decisions back to PC/fetch/writeback logic
    logic             pc_redirect;
    logic [31:0]      pc_target;
    logic             fetch_hold;
    logic             ex_kill;
    logic             ex_commit;
    logic             mul_busy;
    logic [CNT_W-1:0] taken_cnt;
    logic [CNT_W-1:0] stall_cnt;

    modport master (
        output ex_instr_valid, ex_opcode, ex_funct3, ex_funct7,
               alu_result, pc_ex, imm_b_ext, imm_j_ext,
        input  pc_redirect, pc_target, fetch_hold, ex_kill, ex_commit,
               mul_busy, taken_cnt, stall_cnt
    );

    modport slave (
        input  ex_instr_valid, ex_opcode, ex_funct3, ex_funct7,
               alu_result, pc_ex, imm_b_ext, imm_j_ext,
        output pc_redirect, pc_target, fetch_hold, ex_kill, ex_commit,
               mul_busy, taken_cnt, stall_cnt
    );
endinterface

// File: rtl/pipeline_sequencer.sv
// Pipeline sequencer: resolves taken branches/JAL around the EX instruction,
// kills the single wrong-path instruction behind a redirect, holds fetch for
// the duration of a multi-cycle multiply, and keeps saturating counters of
// redirects and stall cycles.
module pipeline_sequencer #(
    parameter int MUL_LAT = 3,
    parameter int CNT_W   = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    pipeline_sequencer_if.slave  bus
);

    typedef enum logic [1:0] {
        ST_RUN  = 2'd0,
        ST_MUL  = 2'd1,
        ST_KILL = 2'd2
    } state_t;

    // A single-cycle multiply commits straight from RUN with no MUL state.
    localparam bit         SINGLE_CYCLE_MUL = (MUL_LAT == 1);
    localparam logic [3:0] MUL_LOAD         = 4'(MUL_LAT - 1);

    state_t     state_q, state_d;
    logic [3:0] cnt_q, cnt_d;

    logic        is_mul;
    logic        is_jal;
    logic        is_branch;
    logic        br_taken;

    logic        redirect_c;
    logic [31:0] target_c;
    logic        hold_c;
    logic        kill_c;
    logic        commit_c;
    logic        busy_c;

    // Performance counters: index 0 counts redirects, index 1 counts stalls.
    logic [1:0]       perf_inc;
    logic [CNT_W-1:0] perf_q [2];

    // Instruction classification of the EX instruction
    always_comb begin
        is_mul    = (bus.ex_opcode == 7'h33) && (bus.ex_funct7 == 7'h01) &&
                    ((bus.ex_funct3 == 3'b000) || (bus.ex_funct3 == 3'b001) ||
                     (bus.ex_funct3 == 3'b011));
        is_jal    = (bus.ex_opcode == 7'h6F);
        is_branch = (bus.ex_opcode == 7'h63);
        br_taken  = 1'b0;
        // beq/bne test a subtraction result; lt/ltu variants test an slt bit
        case (bus.ex_funct3)
            3'b000:        br_taken = (bus.alu_result == 32'd0);
            3'b001:        br_taken = (bus.alu_result != 32'd0);
            3'b100,
            3'b110:        br_taken = bus.alu_result[0];
            3'b101,
            3'b111:        br_taken = ~bus.alu_result[0];
            default:       br_taken = 1'b0;
        endcase
    end

    // Next-state and strobe generation
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        redirect_c = 1'b0;
        target_c   = 32'd0;
        hold_c     = 1'b0;
        kill_c     = 1'b0;
        commit_c   = 1'b0;
        busy_c     = 1'b0;
        case (state_q)
            ST_RUN: begin
                if (bus.ex_instr_valid) begin
                    if (is_mul) begin
                        if (SINGLE_CYCLE_MUL) begin
                            commit_c = 1'b1;
                        end else begin
                            hold_c  = 1'b1;
                            busy_c  = 1'b1;
                            cnt_d   = MUL_LOAD;
                            state_d = ST_MUL;
                        end
                    end else if (is_jal) begin
                        redirect_c = 1'b1;
                        target_c   = bus.pc_ex + bus.imm_j_ext;
                        commit_c   = 1'b1;
                        state_d    = ST_KILL;
                    end else if (is_branch && br_taken) begin
                        redirect_c = 1'b1;
                        target_c   = bus.pc_ex + bus.imm_b_ext;
                        commit_c   = 1'b1;
                        state_d    = ST_KILL;
                    end else begin
                        commit_c = 1'b1;
                    end
                end
            end
            ST_MUL: begin
                // EX inputs are deliberately ignored: the multiply owns EX.
                busy_c = 1'b1;
                cnt_d  = cnt_q - 4'd1;
                if (cnt_q > 4'd1) begin
                    hold_c = 1'b1;
                end else begin
                    commit_c = 1'b1;
                    state_d  = ST_RUN;
                end
            end
            ST_KILL: begin
                // Wrong-path slot: whatever sits in EX becomes a bubble.
                kill_c  = 1'b1;
                state_d = ST_RUN;
            end
            default: begin
                state_d = ST_RUN;
            end
        endcase
    end

    // State and multiply down-counter registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_RUN;
            cnt_q   <= 4'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    assign perf_inc[0] = redirect_c;
    assign perf_inc[1] = hold_c;

    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_perf
            // Saturating event counter
            always_ff @(posedge clk) begin
                if (rst) begin
                    perf_q[gi] <= '0;
                end else if (perf_inc[gi] && (perf_q[gi] != '1)) begin
                    perf_q[gi] <= perf_q[gi] + CNT_W'(1);
                end
            end
        end
    endgenerate

    // Every output reads as zero while reset is held, including counters.
    assign bus.pc_redirect = redirect_c & ~rst;
    assign bus.pc_target   = rst ? 32'd0 : target_c;
    assign bus.fetch_hold  = hold_c & ~rst;
    assign bus.ex_kill     = kill_c & ~rst;
    assign bus.ex_commit   = commit_c & ~rst;
    assign bus.mul_busy    = busy_c & ~rst;
    assign bus.taken_cnt   = rst ? '0 : perf_q[0];
    assign bus.stall_cnt   = rst ? '0 : perf_q[1];

endmodule

// File: tb/tb_pipeline_sequencer.sv
// Bench for pipeline_sequencer: three instances (MUL_LAT 3/1/2, one with
// narrow counters) share one stimulus stream; a cycle-level behavioural model
// predicts every output, with literal checks pinning the directed scenarios.
module tb_pipeline_sequencer;

    localparam int NI = 3;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    pipeline_sequencer_if #(.CNT_W(16)) if_a ();
    pipeline_sequencer_if #(.CNT_W(16)) if_b ();
    pipeline_sequencer_if #(.CNT_W(3))  if_c ();

    pipeline_sequencer #(.MUL_LAT(3), .CNT_W(16)) dut_a (.clk(clk), .rst(rst), .bus(if_a.slave));
    pipeline_sequencer #(.MUL_LAT(1), .CNT_W(16)) dut_b (.clk(clk), .rst(rst), .bus(if_b.slave));
    pipeline_sequencer #(.MUL_LAT(2), .CNT_W(3))  dut_c (.clk(clk), .rst(rst), .bus(if_c.slave));

    typedef struct packed {
        logic        rst;
        logic        valid;
        logic [6:0]  opc;
        logic [2:0]  f3;
        logic [6:0]  f7;
        logic [31:0] alu;
        logic [31:0] pc;
        logic [31:0] immb;
        logic [31:0] immj;
    } stim_t;

    typedef struct packed {
        logic        redirect;
        logic [31:0] target;
        logic        hold;
        logic        kill;
        logic        commit;
        logic        busy;
        logic [63:0] taken;
        logic [63:0] stall;
    } out_t;

    int lat [NI] = '{3, 1, 2};
    int cw  [NI] = '{16, 16, 3};

    // Model state: multiply cycles still owed after the current one, a pending
    // wrong-path kill, and the two event counts.
    int          rem [NI];
    bit          kp  [NI];
    logic [63:0] tk  [NI];
    logic [63:0] st  [NI];

    int   n_cmp  = 0;
    int   n_fail = 0;
    int   n_step = 0;
    out_t last [NI];

    function automatic bit m_is_mul(stim_t s);
        return (s.opc == 7'h33) && (s.f7 == 7'h01) &&
               (s.f3 == 3'd0 || s.f3 == 3'd1 || s.f3 == 3'd3);
    endfunction

    function automatic bit m_taken(stim_t s);
        case (s.f3)
            3'd0:       return s.alu == 32'd0;
            3'd1:       return s.alu != 32'd0;
            3'd4, 3'd6: return s.alu[0] == 1'b1;
            3'd5, 3'd7: return s.alu[0] == 1'b0;
            default:    return 1'b0;
        endcase
    endfunction

    function automatic out_t model_eval(int k, stim_t s);
        out_t o;
        o = '0;
        if (s.rst) return o;
        o.taken = tk[k];
        o.stall = st[k];
        if (rem[k] > 0) begin
            o.busy   = 1'b1;
            o.hold   = (rem[k] > 1);
            o.commit = (rem[k] == 1);
        end else if (kp[k]) begin
            o.kill = 1'b1;
        end else if (s.valid) begin
            if (m_is_mul(s)) begin
                if (lat[k] == 1) o.commit = 1'b1;
                else begin
                    o.hold = 1'b1;
                    o.busy = 1'b1;
                end
            end else if (s.opc == 7'h6F) begin
                o.redirect = 1'b1;
                o.commit   = 1'b1;
                o.target   = s.pc + s.immj;
            end else if (s.opc == 7'h63 && m_taken(s)) begin
                o.redirect = 1'b1;
                o.commit   = 1'b1;
                o.target   = s.pc + s.immb;
            end else begin
                o.commit = 1'b1;
            end
        end
        return o;
    endfunction

    task automatic model_update(int k, stim_t s, out_t o);
        logic [63:0] mx;
        mx = (64'd1 << cw[k]) - 64'd1;
        if (s.rst) begin
            rem[k] = 0;
            kp[k]  = 1'b0;
            tk[k]  = 64'd0;
            st[k]  = 64'd0;
        end else begin
            if (o.redirect && tk[k] < mx) tk[k] = tk[k] + 64'd1;
            if (o.hold && st[k] < mx)     st[k] = st[k] + 64'd1;
            if (rem[k] > 0) rem[k] = rem[k] - 1;
            else if (!kp[k] && s.valid && m_is_mul(s) && lat[k] > 1) rem[k] = lat[k] - 1;
            kp[k] = o.redirect;
        end
    endtask

    function automatic out_t dut_out(int k);
        out_t o;
        o = '0;
        case (k)
            0: o = '{if_a.pc_redirect, if_a.pc_target, if_a.fetch_hold, if_a.ex_kill,
                     if_a.ex_commit, if_a.mul_busy, 64'(if_a.taken_cnt), 64'(if_a.stall_cnt)};
            1: o = '{if_b.pc_redirect, if_b.pc_target, if_b.fetch_hold, if_b.ex_kill,
                     if_b.ex_commit, if_b.mul_busy, 64'(if_b.taken_cnt), 64'(if_b.stall_cnt)};
            default: o = '{if_c.pc_redirect, if_c.pc_target, if_c.fetch_hold, if_c.ex_kill,
                     if_c.ex_commit, if_c.mul_busy, 64'(if_c.taken_cnt), 64'(if_c.stall_cnt)};
        endcase
        return o;
    endfunction

    task automatic chk(string nm, logic [63:0] act, logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (step %0d)", nm, act, exp, n_step);
        end
    endtask

    task automatic drive(stim_t s);
        rst = s.rst;
        if_a.ex_instr_valid = s.valid; if_a.ex_opcode = s.opc; if_a.ex_funct3 = s.f3;
        if_a.ex_funct7 = s.f7; if_a.alu_result = s.alu; if_a.pc_ex = s.pc;
        if_a.imm_b_ext = s.immb; if_a.imm_j_ext = s.immj;
        if_b.ex_instr_valid = s.valid; if_b.ex_opcode = s.opc; if_b.ex_funct3 = s.f3;
        if_b.ex_funct7 = s.f7; if_b.alu_result = s.alu; if_b.pc_ex = s.pc;
        if_b.imm_b_ext = s.immb; if_b.imm_j_ext = s.immj;
        if_c.ex_instr_valid = s.valid; if_c.ex_opcode = s.opc; if_c.ex_funct3 = s.f3;
        if_c.ex_funct7 = s.f7; if_c.alu_result = s.alu; if_c.pc_ex = s.pc;
        if_c.imm_b_ext = s.immb; if_c.imm_j_ext = s.immj;
    endtask

    // One cycle: drive, compare every instance at the falling edge, advance model.
    task automatic step(stim_t s);
        out_t om;
        out_t od;
        drive(s);
        @(negedge clk);
        for (int k = 0; k < NI; k++) begin
            om = model_eval(k, s);
            od = dut_out(k);
            last[k] = od;
            chk($sformatf("u%0d.pc_redirect", k), 64'(od.redirect), 64'(om.redirect));
            chk($sformatf("u%0d.pc_target", k),   64'(od.target),   64'(om.target));
            chk($sformatf("u%0d.fetch_hold", k),  64'(od.hold),     64'(om.hold));
            chk($sformatf("u%0d.ex_kill", k),     64'(od.kill),     64'(om.kill));
            chk($sformatf("u%0d.ex_commit", k),   64'(od.commit),   64'(om.commit));
            chk($sformatf("u%0d.mul_busy", k),    64'(od.busy),     64'(om.busy));
            chk($sformatf("u%0d.taken_cnt", k),   od.taken,         om.taken);
            chk($sformatf("u%0d.stall_cnt", k),   od.stall,         om.stall);
            model_update(k, s, om);
        end
        $display("step %0d rst=%0b v=%0b opc=%02h f3=%0d | A: redir=%0b tgt=%08h hold=%0b kill=%0b commit=%0b busy=%0b taken=%0d stall=%0d",
                 n_step, s.rst, s.valid, s.opc, s.f3, last[0].redirect, last[0].target,
                 last[0].hold, last[0].kill, last[0].commit, last[0].busy,
                 last[0].taken, last[0].stall);
        n_step++;
        @(posedge clk);
        #1;
    endtask

    function automatic stim_t mk(bit r, bit v, logic [6:0] opc, logic [2:0] f3,
                                 logic [6:0] f7, logic [31:0] alu, logic [31:0] pc,
                                 logic [31:0] immb, logic [31:0] immj);
        stim_t s;
        s = '{r, v, opc, f3, f7, alu, pc, immb, immj};
        return s;
    endfunction

    function automatic stim_t rand_stim();
        stim_t s;
        int r;
        s       = '0;
        s.rst   = ($urandom_range(99) == 0);
        s.valid = ($urandom_range(9) != 0);
        r = $urandom_range(99);
        if (r < 25) begin
            s.opc = 7'h33;
            s.f7  = ($urandom_range(4) == 0) ? 7'h00 : 7'h01;
        end else if (r < 40) begin
            s.opc = 7'h6F;
        end else if (r < 75) begin
            s.opc = 7'h63;
        end else begin
            s.opc = 7'($urandom);
            s.f7  = 7'($urandom);
        end
        s.f3 = 3'($urandom);
        case ($urandom_range(4))
            0:       s.alu = 32'd0;
            1:       s.alu = 32'd1;
            2:       s.alu = 32'hFFFF_FFFF;
            default: s.alu = $urandom;
        endcase
        s.pc   = $urandom;
        s.immb = $urandom;
        s.immj = $urandom;
        return s;
    endfunction

    stim_t nop_s, addi_s, mul_s, jal_s;

    initial begin
        nop_s  = mk(0, 0, 7'h00, 3'd0, 7'h00, 32'd0, 32'd0, 32'd0, 32'd0);
        addi_s = mk(0, 1, 7'h13, 3'd0, 7'h00, 32'd5, 32'h200, 32'd0, 32'd0);
        mul_s  = mk(0, 1, 7'h33, 3'd0, 7'h01, 32'd7, 32'h300, 32'd0, 32'd0);
        jal_s  = mk(0, 1, 7'h6F, 3'd0, 7'h00, 32'd0, 32'h400, 32'd0, 32'h40);
        for (int k = 0; k < NI; k++) begin
            rem[k] = 0; kp[k] = 1'b0; tk[k] = 64'd0; st[k] = 64'd0;
        end
        drive(mk(1, 0, 7'h00, 3'd0, 7'h00, 32'd0, 32'd0, 32'd0, 32'd0));
        @(posedge clk);
        #1;

        // Reset held with a taken JAL presented: everything reads zero
        step(mk(1, 1, 7'h6F, 3'd0, 7'h00, 32'd0, 32'h10, 32'd0, 32'h8));
        chk("rst.pc_redirect", 64'(last[0].redirect), 64'd0);
        chk("rst.taken_cnt",   last[0].taken,         64'd0);

        // Taken beq
        step(mk(0, 1, 7'h63, 3'd0, 7'h00, 32'd0, 32'h100, 32'h20, 32'd0));
        chk("beq.pc_redirect", 64'(last[0].redirect), 64'd1);
        chk("beq.pc_target",   64'(last[0].target),   64'h120);
        chk("beq.ex_commit",   64'(last[0].commit),   64'd1);
        step(addi_s);
        chk("beq_kill.ex_kill",   64'(last[0].kill),   64'd1);
        chk("beq_kill.ex_commit", 64'(last[0].commit), 64'd0);
        chk("beq_kill.taken_cnt", last[0].taken,       64'd1);

        // Not-taken bge, then the same operands as blt (taken)
        step(mk(0, 1, 7'h63, 3'd5, 7'h00, 32'd1, 32'h140, 32'h60, 32'd0));
        chk("bge.pc_redirect", 64'(last[0].redirect), 64'd0);
        chk("bge.ex_commit",   64'(last[0].commit),   64'd1);
        step(addi_s);
        chk("bge_next.ex_kill",   64'(last[0].kill),   64'd0);
        chk("bge_next.ex_commit", 64'(last[0].commit), 64'd1);
        step(mk(0, 1, 7'h63, 3'd4, 7'h00, 32'd1, 32'h140, 32'h60, 32'd0));
        chk("blt.pc_redirect", 64'(last[0].redirect), 64'd1);
        chk("blt.pc_target",   64'(last[0].target),   64'h1A0);

        // Taken beq presented in the KILL slot is ignored
        step(mk(0, 1, 7'h63, 3'd0, 7'h00, 32'd0, 32'h500, 32'h20, 32'd0));
        chk("killbeq.pc_redirect", 64'(last[0].redirect), 64'd0);
        chk("killbeq.ex_kill",     64'(last[0].kill),     64'd1);
        step(addi_s);
        chk("killbeq.taken_cnt", last[0].taken, 64'd2);

        // JAL with address wrap
        step(mk(0, 1, 7'h6F, 3'd0, 7'h00, 32'd0, 32'hFFFF_FFF0, 32'd0, 32'h20));
        chk("jal.pc_target", 64'(last[0].target), 64'h10);
        step(nop_s);

        // Multiply: three-cycle and single-cycle instances side by side
        step(mul_s);
        chk("mul0.fetch_hold", 64'(last[0].hold),   64'd1);
        chk("mul0.mul_busy",   64'(last[0].busy),   64'd1);
        chk("mul0_l1.ex_commit",  64'(last[1].commit), 64'd1);
        chk("mul0_l1.fetch_hold", 64'(last[1].hold),   64'd0);
        step(mul_s);
        chk("mul1.fetch_hold", 64'(last[0].hold), 64'd1);
        chk("mul1.mul_busy",   64'(last[0].busy), 64'd1);
        step(mul_s);
        chk("mul2.ex_commit",  64'(last[0].commit), 64'd1);
        chk("mul2.fetch_hold", 64'(last[0].hold),   64'd0);
        chk("mul2.mul_busy",   64'(last[0].busy),   64'd1);
        step(addi_s);
        chk("mul3.mul_busy",     64'(last[0].busy), 64'd0);
        chk("mul3.stall_cnt",    last[0].stall,     64'd2);
        chk("mul3_l1.stall_cnt", last[1].stall,     64'd0);

        // Reset during cycle 1 of a multiply aborts it
        step(mul_s);
        step(mk(1, 1, 7'h33, 3'd0, 7'h01, 32'd7, 32'h300, 32'd0, 32'd0));
        chk("rstmul.ex_commit",  64'(last[0].commit), 64'd0);
        chk("rstmul.mul_busy",   64'(last[0].busy),   64'd0);
        chk("rstmul.fetch_hold", 64'(last[0].hold),   64'd0);
        step(nop_s);
        chk("postrst.ex_commit", 64'(last[0].commit), 64'd0);
        chk("postrst.mul_busy",  64'(last[0].busy),   64'd0);
        chk("postrst.stall_cnt", last[0].stall,       64'd0);
        chk("postrst.taken_cnt", last[0].taken,       64'd0);

        // Randomized traffic
        for (int i = 0; i < 3000; i++) step(rand_stim());

        // Saturation: 40 consecutive JALs give 20 redirects (every other is killed)
        step(mk(1, 0, 7'h00, 3'd0, 7'h00, 32'd0, 32'd0, 32'd0, 32'd0));
        for (int i = 0; i < 40; i++) step(jal_s);
        chk("sat.taken_cnt16", last[0].taken, 64'd20);
        chk("sat.taken_cnt3",  last[2].taken, 64'd7);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/pipeline_sequencer.md
# pipeline_sequencer

Sequences the fetch/execute/writeback pipeline around the instruction held in the EX stage. It resolves taken branches and JAL, redirecting the PC and killing the wrong-path instruction that follows. It holds fetch while a multi-cycle RV32M multiply occupies EX, and qualifies register/GPIO writes with a commit strobe. It also keeps saturating performance counters for redirects and stall cycles. It sits between the EX pipeline register, the ALU result and the PC/fetch logic, beside the control unit.

## Interface
Parameters:
- MUL_LAT, 3: cycles a mul/mulh/mulhu occupies EX, including the first; legal range 1..15.
- CNT_W, 16: width of each performance counter.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  synchronous reset, active-high.
- ex_instr_valid  in  1  EX register holds a real instruction.
- ex_opcode  in  7  opcode of the EX instruction.
- ex_funct3  in  3  funct3 of the EX instruction.
- ex_funct7  in  7  funct7 of the EX instruction.
- alu_result  in  32  ALU output for the EX instruction. Branches use sub or slt/sltu.
- pc_ex  in  32  PC of the EX instruction.
- imm_b_ext  in  32  sign-extended B immediate.
- imm_j_ext  in  32  sign-extended J immediate.
- pc_redirect  out  1  load pc_target into PC this cycle.
- pc_target  out  32  redirect address.
- fetch_hold  out  1  hold PC and the F→EX register.
- ex_kill  out  1  EX instruction is a bubble: no writeback, no GPIO write.
- ex_commit  out  1  EX instruction completes this cycle; qualifies regwrite/gpio_we.
- mul_busy  out  1  multiply in progress.
- taken_cnt  out  CNT_W  count of redirects, saturating.
- stall_cnt  out  CNT_W  count of cycles with fetch_hold=1, saturating.

## Operation
- **States:** RUN, MUL, KILL. There is a 4-bit down-counter `cnt`.
- **Decode, in RUN:**
  - Mul: opcode 0x33, funct7 0x01, funct3 ∈ {000, 001, 011}.
  - JAL: opcode 0x6F.
  - Branch: opcode 0x63.
- **Branch taken rule:**
  - funct3 000: taken if alu_result == 0.
  - funct3 001: taken if alu_result != 0.
  - funct3 100 or 110: taken if alu_result[0] == 1.
  - funct3 101 or 111: taken if alu_result[0] == 0.
  - funct3 010 or 011: never taken.
- **RUN, ex_instr_valid=0:** all strobes are 0. Stay in RUN.
- **RUN, mul:**
  - MUL_LAT=1: ex_commit=1. Stay in RUN.
  - Otherwise: fetch_hold=1, mul_busy=1, ex_commit=0. Load cnt=MUL_LAT-1 and go to MUL.
- **RUN, JAL or taken branch:** pc_redirect=1, ex_commit=1, go to KILL.
  - JAL: pc_target = pc_ex + imm_j_ext.
  - Branch: pc_target = pc_ex + imm_b_ext.
  - Addition is modulo 2^32.
- **RUN, any other valid instruction,** including a not-taken branch: ex_commit=1. Stay in RUN.
- **MUL:**
  - Every cycle: mul_busy=1, and cnt decrements.
  - cnt > 1: fetch_hold=1, ex_commit=0.
  - cnt == 1: fetch_hold=0, ex_commit=1, next state RUN.
  - The EX inputs are not re-decoded in MUL.
- **KILL:**
  - Lasts exactly one cycle, then returns to RUN.
  - ex_kill=1, ex_commit=0, pc_redirect=0.
  - A branch/JAL/mul presented in this cycle is ignored because it is wrong-path.
- **pc_target:** 0 whenever pc_redirect=0.
- **Counters:**
  - taken_cnt increments on each cycle with pc_redirect=1.
  - stall_cnt increments on each cycle with fetch_hold=1.
  - Both hold at 2^CNT_W-1.

## Timing
- All strobes and pc_target are combinational from the state and the EX inputs of the same cycle. State, cnt and counters are registered.
- **Redirect:** the taken instruction commits in cycle N. The fall-through instruction fetched in N is killed in N+1. The target instruction is in EX at N+2. Penalty is 1 bubble.
- **Mul:** occupies EX for exactly MUL_LAT cycles, with commit in the last one. fetch_hold is high for MUL_LAT-1 cycles.
- **Reset:**
  - While rst=1, all outputs are forced to 0.
  - On the edge: state=RUN, cnt=0, taken_cnt=0, stall_cnt=0.
  - Reset mid-MUL or in KILL aborts the operation. No ex_commit is issued for the aborted instruction.
- **Back-to-back:**
  - A mul immediately following a completed mul re-enters MUL from RUN.
  - A branch immediately after a KILL cycle is evaluated normally.

## Test plan
- **Taken beq:** ex_opcode=0x63, funct3=000, alu_result=0, pc_ex=0x100, imm_b_ext=0x20 → pc_redirect=1, pc_target=0x120, ex_commit=1. Next cycle ex_kill=1, ex_commit=0. Then RUN. taken_cnt=1.
- **Not-taken bge:** funct3=101, alu_result=1 → pc_redirect=0, ex_commit=1, no KILL cycle. Same stimulus with funct3=100 → taken.
- **JAL wrap:** opcode=0x6F, pc_ex=0xFFFFFFF0, imm_j_ext=0x20 → pc_target=0x00000010.
- **Mul, MUL_LAT=3:**
  - Cycle 0: fetch_hold=1, mul_busy=1.
  - Cycle 1: fetch_hold=1, mul_busy=1.
  - Cycle 2: ex_commit=1, fetch_hold=0, mul_busy=1.
  - Cycle 3: RUN with mul_busy=0. stall_cnt=2.
  - With MUL_LAT=1 instead: commit in cycle 0 and stall_cnt stays 0.
- **Reset mid-mul:** assert rst during cycle 1 of a mul → all outputs 0 while asserted. After release: RUN, counters 0, no commit for the aborted mul.
- **KILL ignores branch:** a taken beq is presented during the KILL cycle → pc_redirect=0, ex_kill=1, taken_cnt unchanged.
